mem_lsu_port: RTL

- Parametrised single-port synchronous data memory for the RV32I core, with a valid/ready request/response handshake.
- Takes RV32I load/store requests as byte address, funct3 and store data. It generates byte lanes internally, detects misaligned, out-of-range and illegal-size accesses, and returns sign- or zero-extended load data.
- Sits between the core's load/store stage and the on-chip block RAM. It is the successor to the fixed 2 KiB byte-mask wrapper.

---
 rtl/mem_lsu_port.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mem_lsu_port.sv
// RV32I load/store port onto a byte-enable synchronous block RAM, with valid/ready
// request and response handshakes, lane generation, load extension and fault detection.
module mem_lsu_port #(
   parameter int unsigned DEPTH_WORDS = 2048,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter string       INIT_FILE   = ""
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [2:0]            req_funct3_i,
   input  logic [31:0]           req_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [31:0]           rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  rsp_misaligned_o
);
   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

   logic             w_accept;
   logic             w_illegal;
   logic             w_misaligned;
   logic             w_oor;
   logic             w_fault;
   logic             w_wr_en;
   logic             w_rd_en;
   logic [IDX_W-1:0] w_idx;
   logic [1:0]       w_off;
   logic [3:0]       w_lanes;
   logic [31:0]      w_wdata_rep;
   logic [31:0]      w_ram_q;
   logic [7:0]       w_byte;
   logic [15:0]      w_half;
   logic [31:0]      w_rdata;

   logic             r_rsp_valid;
   logic             r_err;
   logic             r_mis;
   logic             r_ld_ok;
   logic [2:0]       r_f3;
   logic [1:0]       r_off;

   assign req_ready_o = !rst_i && (!r_rsp_valid || rsp_ready_i);
   assign w_accept    = req_valid_i && req_ready_o;
   assign w_idx       = req_addr_i[IDX_W+1:2];
   assign w_off       = req_addr_i[1:0];

   always_comb begin
      w_illegal    = 1'b0;
      w_misaligned = 1'b0;
      w_lanes      = 4'b0000;
      w_wdata_rep  = req_wdata_i;
      case (req_funct3_i)
         3'b000: begin
            w_lanes     = 4'b0001 << w_off;
            w_wdata_rep = {4{req_wdata_i[7:0]}};
         end
         3'b001: begin
            w_lanes      = 4'b0011 << w_off;
            w_wdata_rep  = {2{req_wdata_i[15:0]}};
            w_misaligned = w_off[0];
         end
         3'b010: begin
            w_lanes      = 4'b1111;
            w_misaligned = |w_off;
         end
         3'b100: w_illegal = req_we_i;
         3'b101: begin
            w_illegal    = req_we_i;
            w_misaligned = w_off[0];
         end
         default: w_illegal = 1'b1;
      endcase
   end

   // Any byte-address bit above the word index means the access is past the array.
   if (ADDR_WIDTH > IDX_W + 2) begin : g_oor
      assign w_oor = |req_addr_i[ADDR_WIDTH-1:IDX_W+2];
   end else begin : g_no_oor
      assign w_oor = 1'b0;
   end

   assign w_fault = w_illegal || w_misaligned || w_oor;
   assign w_wr_en = w_accept && req_we_i && !w_fault;
   assign w_rd_en = w_accept && !req_we_i && !w_fault;

   for (genvar gl = 0; gl < 4; gl++) begin : g_lane
      logic [7:0] r_mem [DEPTH_WORDS];
      logic [7:0] r_rd;

      always_ff @(posedge clk_i) begin
         if (w_wr_en && w_lanes[gl]) begin
            r_mem[w_idx] <= w_wdata_rep[gl*8 +: 8];
         end
         if (w_rd_en) begin
            r_rd <= r_mem[w_idx];
         end
      end
   end

   assign w_ram_q = {g_lane[3].r_rd, g_lane[2].r_rd, g_lane[1].r_rd, g_lane[0].r_rd};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rsp_valid <= 1'b0;
         r_err       <= 1'b0;
         r_mis       <= 1'b0;
         r_ld_ok     <= 1'b0;
         r_f3        <= 3'b000;
         r_off       <= 2'b00;
      end else if (w_accept) begin
         r_rsp_valid <= 1'b1;
         r_err       <= w_fault;
         r_mis       <= !w_illegal && w_misaligned;
         r_ld_ok     <= !req_we_i && !w_fault;
         r_f3        <= req_funct3_i;
         r_off       <= w_off;
      end else if (rsp_ready_i) begin
         r_rsp_valid <= 1'b0;
      end
   end

   // Extension works on the held RAM output, so the result stays stable across stalls.
   always_comb begin
      w_byte  = w_ram_q[{r_off, 3'b000} +: 8];
      w_half  = w_ram_q[{r_off[1], 4'b0000} +: 16];
      w_rdata = 32'h0;
      if (r_ld_ok) begin
         case (r_f3)
            3'b000:  w_rdata = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_rdata = {24'h0, w_byte};
            3'b001:  w_rdata = {{16{w_half[15]}}, w_half};
            3'b101:  w_rdata = {16'h0, w_half};
            default: w_rdata = w_ram_q;
         endcase
      end
   end

   assign rsp_valid_o      = r_rsp_valid;
   assign rsp_rdata_o      = w_rdata;
   assign rsp_err_o        = r_err;
   assign rsp_misaligned_o = r_mis;

endmodule
